// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared constants and state encoding for the FFT serial link
package serial_link_pkg;

    // Defaults shared by the transmitter and the receiver so both ends agree on framing.
    localparam int WORD_W_DEF      = 12;
    localparam int NUM_WORDS_DEF   = 2048;
    localparam int LEAD_CYCLES_DEF = 2;
    localparam int CYC_PER_BIT_DEF = 2;

    // Number of cycles next_data stays high for one complete frame.
    localparam int FRAME_CYCLES = LEAD_CYCLES_DEF + CYC_PER_BIT_DEF * WORD_W_DEF * NUM_WORDS_DEF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LEAD     = 3'd1,
        BIT_A    = 3'd2,
        BIT_B    = 3'd3,
        WAIT_LOW = 3'd4
    } link_state_e;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// rtl/serial_frame_receiver_if.sv - serial link input and word output bundle
// Signals: next_data/data (serial side), word_out/word_idx/word_valid,
// frame_done/frame_err/busy (word side), peak_mag/peak_idx when SR_PEAK_DETECT_EN.
// master: transmitter/consumer side; slave: the receiver.
interface serial_frame_receiver_if #(
    parameter int WORD_W = 12,
    parameter int IDX_W  = 11
);
    logic              next_data;
    logic              data;
    logic [WORD_W-1:0] word_out;
    logic [IDX_W-1:0]  word_idx;
    logic              word_valid;
    logic              frame_done;
    logic              frame_err;
    logic              busy;
`ifdef SR_PEAK_DETECT_EN
    logic [WORD_W-1:0] peak_mag;
    logic [IDX_W-1:0]  peak_idx;

    modport master (output next_data, data,
                    input  word_out, word_idx, word_valid, frame_done, frame_err, busy,
                           peak_mag, peak_idx);
    modport slave  (input  next_data, data,
                    output word_out, word_idx, word_valid, frame_done, frame_err, busy,
                           peak_mag, peak_idx);
`else
    modport master (output next_data, data,
                    input  word_out, word_idx, word_valid, frame_done, frame_err, busy);
    modport slave  (input  next_data, data,
                    output word_out, word_idx, word_valid, frame_done, frame_err, busy);
`endif
endinterface

// File: rtl/serial_peak_tracker.sv
// rtl/serial_peak_tracker.sv - running maximum of a frame's words, DC bin excluded
// Ports: clk, reset_n, i_load (word being registered), i_word, i_idx,
// i_clear (frame aborted), o_peak_mag, o_peak_idx.
module serial_peak_tracker #(
    parameter int WORD_W = 12,
    parameter int IDX_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_clear,
    output logic [WORD_W-1:0] o_peak_mag,
    output logic [IDX_W-1:0]  o_peak_idx
);

    logic [WORD_W-1:0] r_mag;
    logic [IDX_W-1:0]  r_idx;

    // Updated in the same cycle word_out is registered, so the result already
    // includes the last bin when frame_done is seen. Bin 0 restarts the search
    // instead of competing; strict compare keeps the earliest index on ties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mag <= '0;
            r_idx <= '0;
        end else if (i_clear) begin
            r_mag <= '0;
            r_idx <= '0;
        end else if (i_load) begin
            if (i_idx == '0) begin
                r_mag <= '0;
                r_idx <= '0;
            end else if (i_word > r_mag) begin
                r_mag <= i_word;
                r_idx <= i_idx;
            end
        end
    end

    assign o_peak_mag = r_mag;
    assign o_peak_idx = r_idx;

endmodule

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - deserializes the FFT serial link into indexed words
// Ports: clk, reset_n (async, active-low), link (serial_frame_receiver_if.slave).
// Optional macro SR_PEAK_DETECT_EN adds peak_mag/peak_idx via serial_peak_tracker.
module serial_frame_receiver
    import serial_link_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int NUM_WORDS   = NUM_WORDS_DEF,
    parameter int LEAD_CYCLES = LEAD_CYCLES_DEF,
    parameter int CYC_PER_BIT = CYC_PER_BIT_DEF,
    parameter int IDX_W       = $clog2(NUM_WORDS)
) (
    input  logic clk,
    input  logic reset_n,
    serial_frame_receiver_if.slave link
);

    localparam int PH_MAX = (LEAD_CYCLES > CYC_PER_BIT) ? LEAD_CYCLES : CYC_PER_BIT;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int BC_W   = $clog2(WORD_W);

    link_state_e       r_state, w_state_nxt;
    logic [PH_W-1:0]   r_phase, w_phase_nxt;
    logic [BC_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [IDX_W-1:0]  r_word_cnt, w_word_cnt_nxt;
    logic [WORD_W-1:0] r_shift, w_shift_nxt, w_shift_in;
    logic [WORD_W-1:0] r_word_out;
    logic [IDX_W-1:0]  r_word_idx;
    logic              r_word_valid, r_frame_done, r_frame_err;
    logic              w_valid_nxt, w_done_nxt, w_err_nxt, w_load;

    assign w_shift_in = {r_shift[WORD_W-2:0], link.data};

    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_word_cnt_nxt = r_word_cnt;
        w_shift_nxt    = r_shift;
        w_valid_nxt    = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_load         = 1'b0;

        // Any drop of next_data while a frame is in flight aborts it, including
        // the cycle of the final sample.
        if ((r_state == LEAD || r_state == BIT_A || r_state == BIT_B) && !link.next_data) begin
            w_state_nxt    = IDLE;
            w_phase_nxt    = '0;
            w_bit_cnt_nxt  = '0;
            w_word_cnt_nxt = '0;
            w_shift_nxt    = '0;
            w_err_nxt      = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    // This cycle already counts as the first lead cycle.
                    if (link.next_data) begin
                        w_state_nxt = LEAD;
                        w_phase_nxt = PH_W'(1);
                    end
                end
                LEAD: begin
                    if (r_phase == PH_W'(LEAD_CYCLES - 1)) begin
                        w_state_nxt = BIT_A;
                        w_phase_nxt = PH_W'(1);
                    end else begin
                        w_phase_nxt = r_phase + PH_W'(1);
                    end
                end
                BIT_A: begin
                    if (r_phase == PH_W'(CYC_PER_BIT - 1)) begin
                        w_state_nxt = BIT_B;
                    end else begin
                        w_phase_nxt = r_phase + PH_W'(1);
                    end
                end
                BIT_B: begin
                    w_shift_nxt = w_shift_in;
                    w_phase_nxt = PH_W'(1);
                    w_state_nxt = BIT_A;
                    if (r_bit_cnt == BC_W'(WORD_W - 1)) begin
                        w_load        = 1'b1;
                        w_valid_nxt   = 1'b1;
                        w_bit_cnt_nxt = '0;
                        if (r_word_cnt == IDX_W'(NUM_WORDS - 1)) begin
                            w_done_nxt     = 1'b1;
                            w_word_cnt_nxt = '0;
                            w_state_nxt    = WAIT_LOW;
                            w_phase_nxt    = '0;
                        end else begin
                            w_word_cnt_nxt = r_word_cnt + IDX_W'(1);
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
                    end
                end
                WAIT_LOW: begin
                    if (!link.next_data) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_phase      <= '0;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_shift      <= '0;
            r_word_out   <= '0;
            r_word_idx   <= '0;
            r_word_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_word_valid <= w_valid_nxt;
            r_frame_done <= w_done_nxt;
            r_frame_err  <= w_err_nxt;
            if (w_load) begin
                r_word_out <= w_shift_in;
                r_word_idx <= r_word_cnt;
            end
        end
    end

    assign link.word_out   = r_word_out;
    assign link.word_idx   = r_word_idx;
    assign link.word_valid = r_word_valid;
    assign link.frame_done = r_frame_done;
    assign link.frame_err  = r_frame_err;
    assign link.busy       = (r_state == LEAD) || (r_state == BIT_A) || (r_state == BIT_B);

`ifdef SR_PEAK_DETECT_EN
    serial_peak_tracker #(
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_peak (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_word     (w_shift_in),
        .i_idx      (r_word_cnt),
        .i_clear    (w_err_nxt),
        .o_peak_mag (link.peak_mag),
        .o_peak_idx (link.peak_idx)
    );
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - directed self-checking bench for serial_frame_receiver
module tb_serial_frame_receiver;

    localparam int WORD_W      = 12;
    localparam int NUM_WORDS   = 256;
    localparam int IDX_W       = 8;
    localparam int LEAD_CYCLES = 2;
    localparam int CYC_PER_BIT = 2;

    logic clk = 1'b0;
    logic reset_n;

    int checks = 0;
    int errors = 0;
    int valid_count = 0;
    int done_count = 0;
    int err_count = 0;
    int exp_idx = 0;

    logic [WORD_W-1:0] exp_word [NUM_WORDS];
    logic [WORD_W-1:0] got_word [NUM_WORDS];

    serial_frame_receiver_if #(.WORD_W(WORD_W), .IDX_W(IDX_W)) link ();

    serial_frame_receiver #(
        .WORD_W      (WORD_W),
        .NUM_WORDS   (NUM_WORDS),
        .LEAD_CYCLES (LEAD_CYCLES),
        .CYC_PER_BIT (CYC_PER_BIT),
        .IDX_W       (IDX_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .link    (link)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        valid_count = 0;
        done_count  = 0;
        err_count   = 0;
        exp_idx     = 0;
    endtask

    // Drives one frame: nwords full words plus pbits extra bits, extra high
    // cycles afterwards, optional drop on the final sample cycle, optional
    // leaving next_data high on return.
    task automatic drive_frame(input int nwords, input int pbits, input int extra,
                               input bit drop_last, input bit keep_high);
        int nbits;
        nbits = nwords * WORD_W + pbits;
        link.next_data = 1'b1;
        link.data      = 1'b0;
        tick();
        chk("busy_in_lead", link.busy, 1);
        for (int c = 1; c < LEAD_CYCLES; c++) tick();
        for (int n = 0; n < nbits; n++) begin
            link.data = exp_word[n / WORD_W][WORD_W-1-(n % WORD_W)];
            for (int c = 0; c < CYC_PER_BIT; c++) begin
                if (drop_last && n == nbits - 1 && c == CYC_PER_BIT - 1) link.next_data = 1'b0;
                tick();
            end
        end
        for (int e = 0; e < extra; e++) tick();
        if (extra > 0) begin
            chk("extra_busy", link.busy, 0);
            chk("extra_valid_count", valid_count, NUM_WORDS);
            chk("extra_done_count", done_count, 1);
        end
        if (!keep_high) begin
            link.next_data = 1'b0;
            link.data      = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (link.word_valid) begin
            chk("word_idx_seq", link.word_idx, exp_idx);
            chk("word_out", link.word_out, exp_word[link.word_idx]);
            got_word[link.word_idx] = link.word_out;
            exp_idx++;
            valid_count++;
        end
        if (link.frame_done) begin
            chk("done_with_valid", link.word_valid, 1);
            chk("done_idx", link.word_idx, NUM_WORDS - 1);
            done_count++;
        end
        if (link.frame_err) err_count++;
    end

    initial begin
        reset_n        = 1'b0;
        link.next_data = 1'b0;
        link.data      = 1'b0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            exp_word[k] = WORD_W'(k);
            got_word[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_word_out", link.word_out, 0);
        chk("rst_word_idx", link.word_idx, 0);
        chk("rst_word_valid", link.word_valid, 0);
        chk("rst_frame_done", link.frame_done, 0);
        chk("rst_frame_err", link.frame_err, 0);
        chk("rst_busy", link.busy, 0);
        reset_n = 1'b1;
        tick();
        tick();

        // Full frame, word k = k.
        clear_counts();
        drive_frame(NUM_WORDS, 0, 0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("f1_valid_count", valid_count, NUM_WORDS);
        chk("f1_done_count", done_count, 1);
        chk("f1_err_count", err_count, 0);
        chk("f1_busy", link.busy, 0);
        chk("f1_last_word", link.word_out, NUM_WORDS - 1);

        // Abort after 5 words and 7 bits, then a clean frame.
        clear_counts();
        drive_frame(5, 7, 0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("ab_valid_count", valid_count, 5);
        chk("ab_err_count", err_count, 1);
        chk("ab_done_count", done_count, 0);
        chk("ab_busy", link.busy, 0);
        chk("ab_last_idx", link.word_idx, 4);
        clear_counts();
        drive_frame(NUM_WORDS, 0, 0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("ab2_valid_count", valid_count, NUM_WORDS);
        chk("ab2_done_count", done_count, 1);
        chk("ab2_err_count", err_count, 0);

        // Ten extra high cycles after the final bit.
        clear_counts();
        drive_frame(NUM_WORDS, 0, 10, 1'b0, 1'b0);
        repeat (3) tick();
        chk("ex_valid_count", valid_count, NUM_WORDS);
        chk("ex_done_count", done_count, 1);
        chk("ex_err_count", err_count, 0);

        // MSB-first ordering: 0x800 at idx 3, 0xFFF at idx 4.
        for (int k = 0; k < NUM_WORDS; k++) exp_word[k] = WORD_W'((k * 7) % 4096);
        exp_word[3] = 12'h800;
        exp_word[4] = 12'hFFF;
        clear_counts();
        drive_frame(NUM_WORDS, 0, 0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("msb_word3", got_word[3], 12'h800);
        chk("msb_word4", got_word[4], 12'hFFF);
        chk("msb_valid_count", valid_count, NUM_WORDS);

        // next_data low on the final sample cycle: abort, no frame_done.
        clear_counts();
        drive_frame(NUM_WORDS, 0, 0, 1'b1, 1'b0);
        repeat (3) tick();
        chk("dl_valid_count", valid_count, NUM_WORDS - 1);
        chk("dl_done_count", done_count, 0);
        chk("dl_err_count", err_count, 1);
        chk("dl_busy", link.busy, 0);

        // Asynchronous reset in the middle of word 100.
        clear_counts();
        drive_frame(100, 5, 0, 1'b0, 1'b1);
        chk("pre_rst_idx", link.word_idx, 99);
        chk("pre_rst_busy", link.busy, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_word_out", link.word_out, 0);
        chk("mid_rst_word_idx", link.word_idx, 0);
        chk("mid_rst_valid", link.word_valid, 0);
        chk("mid_rst_done", link.frame_done, 0);
        chk("mid_rst_err", link.frame_err, 0);
        chk("mid_rst_busy", link.busy, 0);
        link.next_data = 1'b0;
        link.data      = 1'b0;
        tick();
        reset_n = 1'b1;
        clear_counts();
        repeat (3) tick();
        chk("post_rst_valid", valid_count, 0);
        chk("post_rst_err", err_count, 0);
        chk("post_rst_done", done_count, 0);
        drive_frame(NUM_WORDS, 0, 0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("post_rst_frame_valid", valid_count, NUM_WORDS);
        chk("post_rst_frame_done", done_count, 1);
        chk("post_rst_frame_err", err_count, 0);

`ifdef SR_PEAK_DETECT_EN
        // DC bin is the largest but excluded; tie between 37 and 200 keeps 37.
        for (int k = 0; k < NUM_WORDS; k++) exp_word[k] = 12'h010;
        exp_word[0]   = 12'hFFF;
        exp_word[37]  = 12'h9A0;
        exp_word[200] = 12'h9A0;
        clear_counts();
        drive_frame(NUM_WORDS, 0, 0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("peak_mag", link.peak_mag, 12'h9A0);
        chk("peak_idx", link.peak_idx, 37);
        chk("peak_done_count", done_count, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
